rapids: RTL and testbench

- Minimal multi-cycle 32-bit processor core with internal instruction/data memory and a 16-entry register file.
- Idle after reset; on `go` it executes word-addressed instructions from address 0 until `halt`, a HLT instruction, or reset.
- Top-level compute block; the bench drives only clock, reset, `go` and `halt`.
- Memory and register file are preloaded hierarchically by the bench.

---
 rtl/rapids_pkg.sv | 46 ++++
 rtl/rapids_mmu.sv | 31 +++
 rtl/rapids_regfile.sv | 27 ++
 rtl/rapids.sv | 106 ++++++++++
 tb/tb_rapids.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rapids_pkg.sv
// rtl/rapids_pkg.sv - shared constants, state encoding and ALU helper for the rapids core
package rapids_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [7:0] OP_LDI = 8'h9E;
    localparam logic [7:0] OP_ALU = 8'h80;
    localparam logic [7:0] OP_HLT = 8'hFF;

    localparam logic [7:0] FN_ADD = 8'h80;
    localparam logic [7:0] FN_SUB = 8'h81;
    localparam logic [7:0] FN_AND = 8'h82;
    localparam logic [7:0] FN_OR  = 8'h83;
    localparam logic [7:0] FN_XOR = 8'h84;

    localparam int REG_AW = 4;

    // instruction field positions
    localparam int OPC_HI = 31, OPC_LO = 24;
    localparam int FN_HI  = 23, FN_LO  = 16;
    localparam int LRD_HI = 19, LRD_LO = 16;
    localparam int RS1_HI = 15, RS1_LO = 12;
    localparam int ARD_HI = 11, ARD_LO = 8;
    localparam int RS2_HI = 7,  RS2_LO = 4;
    localparam int IMM_HI = 15, IMM_LO = 0;

    // returns {write_enable, result}; unknown functs suppress the write
    function automatic logic [32:0] alu_op(input logic [7:0] funct,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        case (funct)
            FN_ADD:  return {1'b1, a + b};
            FN_SUB:  return {1'b1, a - b};
            FN_AND:  return {1'b1, a & b};
            FN_OR:   return {1'b1, a | b};
            FN_XOR:  return {1'b1, a ^ b};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

endpackage

// File: rtl/rapids_mmu.sv
// rtl/rapids_mmu.sv - word-addressed memory with registered read port
module rapids_mmu #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] memory [0:WORDS-1];

    // array storage is never reset so preloaded contents survive rst_n
    always_ff @(posedge clk) begin
        if (we)
            memory[addr] <= wdata;
    end

    // registered read doubles as the instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= 32'h0;
        else if (rd_en)
            rdata <= memory[addr];
    end

endmodule

// File: rtl/rapids_regfile.sv
// rtl/rapids_regfile.sv - register file with two combinational reads and one write
module rapids_regfile #(
    parameter int NREGS = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr1,
    output logic [31:0]   rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [31:0]   rdata2
);

    logic [31:0] registers [0:NREGS-1];

    // no hardwired zero; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we)
            registers[waddr] <= wdata;
    end

    assign rdata1 = registers[raddr1];
    assign rdata2 = registers[raddr2];

endmodule

// File: rtl/rapids.sv
// rtl/rapids.sv - two-cycle-per-instruction 32-bit core with internal memory and registers
module rapids
    import rapids_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int NREGS     = 16,
    parameter int PC_W      = $clog2(MEM_WORDS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go,
    input  logic            halt,
    output logic            busy,
    output logic [PC_W-1:0] pc
);

    state_t state, state_n;

    logic [31:0]       ir;
    logic [7:0]        opcode;
    logic [7:0]        funct;
    logic [REG_AW-1:0] rs1, rs2, rd_alu, rd_ldi;
    logic [31:0]       rs1_data, rs2_data;
    logic              reg_we;
    logic [REG_AW-1:0] reg_waddr;
    logic [31:0]       reg_wdata;
    logic [32:0]       alu_res;
    logic              unused_ir;

    assign opcode    = ir[OPC_HI:OPC_LO];
    assign funct     = ir[FN_HI:FN_LO];
    assign rs1       = ir[RS1_HI:RS1_LO];
    assign rs2       = ir[RS2_HI:RS2_LO];
    assign rd_alu    = ir[ARD_HI:ARD_LO];
    assign rd_ldi    = ir[LRD_HI:LRD_LO];
    assign unused_ir = ^ir[3:0];
    assign alu_res   = alu_op(funct, rs1_data, rs2_data);
    assign busy      = (state == S_FETCH) || (state == S_EXEC);

    rapids_mmu #(.WORDS(MEM_WORDS), .AW(PC_W)) mmu (
        .clk   (clk),
        .rst_n (rst_n),
        .rd_en (state == S_FETCH),
        .we    (1'b0),
        .addr  (pc),
        .wdata (32'h0),
        .rdata (ir)
    );

    rapids_regfile #(.NREGS(NREGS), .AW(REG_AW)) D (
        .clk    (clk),
        .we     (reg_we),
        .waddr  (reg_waddr),
        .wdata  (reg_wdata),
        .raddr1 (rs1),
        .rdata1 (rs1_data),
        .raddr2 (rs2),
        .rdata2 (rs2_data)
    );

    // state register and program counter; pc only advances at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            state <= state_n;
            if (state == S_EXEC)
                pc <= pc + PC_W'(1);
        end
    end

    // next state: halt wins over go in IDLE and is sampled only at the end of EXEC
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (go && !halt) state_n = S_FETCH;
            S_FETCH:  state_n = S_EXEC;
            S_EXEC:   state_n = (halt || opcode == OP_HLT) ? S_HALTED : S_FETCH;
            S_HALTED: state_n = S_HALTED;
            default:  state_n = S_IDLE;
        endcase
    end

    // decode and writeback, active only during EXEC
    always_comb begin
        reg_we    = 1'b0;
        reg_waddr = rd_ldi;
        reg_wdata = 32'h0;
        if (state == S_EXEC) begin
            case (opcode)
                OP_LDI: begin
                    reg_we    = 1'b1;
                    reg_wdata = {16'h0, ir[IMM_HI:IMM_LO]};
                end
                OP_ALU: begin
                    reg_we    = alu_res[32];
                    reg_waddr = rd_alu;
                    reg_wdata = alu_res[31:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rapids.sv
// tb/tb_rapids.sv - scoreboard bench for the rapids core
module tb_rapids;

    logic       clk;
    logic       rst_n;
    logic       go;
    logic       halt;
    logic       busy;
    logic [7:0] pc;

    rapids dut (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .halt  (halt),
        .busy  (busy),
        .pc    (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] K_PC = 2'd0, K_BUSY = 2'd1, K_REG = 2'd2, K_MEM = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  idx;
        logic [31:0] value;
    } chk_t;

    chk_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic expect_val(input logic [1:0] kind, input logic [7:0] idx,
                              input logic [31:0] value, input string name);
        chk_t c;
        c.kind  = kind;
        c.idx   = idx;
        c.value = value;
        exp_q.push_back(c);
        name_q.push_back(name);
    endtask

    // monitor: compares every queued expectation against the DUT on the falling edge
    initial begin
        chk_t        c;
        string       nm;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                c  = exp_q.pop_front();
                nm = name_q.pop_front();
                case (c.kind)
                    K_PC:    act = {24'h0, pc};
                    K_BUSY:  act = {31'h0, busy};
                    K_REG:   act = dut.D.registers[c.idx[3:0]];
                    default: act = dut.mmu.memory[c.idx];
                endcase
                n_checks++;
                if (act !== c.value) begin
                    n_fail++;
                    $display("FAIL %s: got %08h expected %08h", nm, act, c.value);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got busy=1 expected busy=0", name);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        go    = 1'b0;
        halt  = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) dut.mmu.memory[i] = 32'h0;
        for (int i = 0; i < 16; i++)  dut.D.registers[i] = 32'h0;
        @(posedge clk);
        #1;
        expect_val(K_PC, 0, 32'h0, "reset_pc");
        expect_val(K_BUSY, 0, 32'h0, "reset_busy");
        drain();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        go    = 1'b0;
        halt  = 1'b0;

        // basic program with idle hold first
        do_reset();
        dut.mmu.memory[0] = 32'h9E010004;
        dut.mmu.memory[1] = 32'h9E020006;
        dut.mmu.memory[2] = 32'h80801020;
        dut.D.registers[0] = 32'd16;
        tick(20);
        expect_val(K_PC, 0, 32'h0, "idle_pc");
        expect_val(K_BUSY, 0, 32'h0, "idle_busy");
        expect_val(K_REG, 0, 32'd16, "idle_r0");
        drain();
        go = 1'b1;
        tick(7);
        expect_val(K_PC, 0, 32'd3, "basic_pc");
        expect_val(K_BUSY, 0, 32'h1, "basic_busy");
        expect_val(K_REG, 1, 32'd4, "basic_r1");
        expect_val(K_REG, 2, 32'd6, "basic_r2");
        expect_val(K_REG, 0, 32'd10, "basic_r0");
        drain();

        // halt in IDLE blocks start even with go high
        do_reset();
        halt = 1'b1;
        go   = 1'b1;
        tick(5);
        expect_val(K_PC, 0, 32'h0, "halt_idle_pc");
        expect_val(K_BUSY, 0, 32'h0, "halt_idle_busy");
        drain();

        // ALU ops, unknown funct, then HLT
        do_reset();
        dut.D.registers[1] = 32'hFFFFFFFF;
        dut.D.registers[2] = 32'h00000001;
        dut.D.registers[8] = 32'h00000055;
        dut.mmu.memory[0] = 32'h80801320;
        dut.mmu.memory[1] = 32'h80812410;
        dut.mmu.memory[2] = 32'h80841520;
        dut.mmu.memory[3] = 32'h80821620;
        dut.mmu.memory[4] = 32'h80831720;
        dut.mmu.memory[5] = 32'h80851820;
        dut.mmu.memory[6] = 32'hFF000000;
        go = 1'b1;
        tick(1);
        go = 1'b0;
        wait_idle(60, "alu");
        expect_val(K_REG, 3, 32'h00000000, "alu_add_wrap");
        expect_val(K_REG, 4, 32'h00000002, "alu_sub");
        expect_val(K_REG, 5, 32'hFFFFFFFE, "alu_xor");
        expect_val(K_REG, 6, 32'h00000001, "alu_and");
        expect_val(K_REG, 7, 32'hFFFFFFFF, "alu_or");
        expect_val(K_REG, 8, 32'h00000055, "alu_unknown_funct");
        expect_val(K_PC, 0, 32'd7, "alu_pc");
        drain();

        // HLT instruction stops before the following LDI
        do_reset();
        dut.mmu.memory[0] = 32'h9E030007;
        dut.mmu.memory[1] = 32'hFF000000;
        dut.mmu.memory[2] = 32'h9E03FFFF;
        go = 1'b1;
        tick(1);
        wait_idle(30, "hlt");
        tick(5);
        expect_val(K_REG, 3, 32'd7, "hlt_r3");
        expect_val(K_PC, 0, 32'd2, "hlt_pc");
        expect_val(K_BUSY, 0, 32'h0, "hlt_busy");
        drain();

        // halt request mid-run lets the instruction in flight finish
        do_reset();
        for (int i = 0; i < 10; i++) begin
            dut.mmu.memory[i]  = 32'h9E000000 | (i << 16) | (32'h100 + i);
            dut.D.registers[i] = 32'h0000DEAD;
        end
        go = 1'b1;
        tick(6);
        halt = 1'b1;
        tick(1);
        expect_val(K_PC, 0, 32'd3, "halt_pc");
        expect_val(K_BUSY, 0, 32'h0, "halt_busy");
        expect_val(K_REG, 1, 32'h101, "halt_r1");
        expect_val(K_REG, 2, 32'h102, "halt_r2_completes");
        expect_val(K_REG, 3, 32'h0000DEAD, "halt_r3_untouched");
        drain();
        halt = 1'b0;
        go   = 1'b0;
        tick(1);
        go = 1'b1;
        tick(2);
        go = 1'b0;
        tick(3);
        expect_val(K_PC, 0, 32'd3, "halted_frozen_pc");
        expect_val(K_BUSY, 0, 32'h0, "halted_frozen_busy");
        expect_val(K_REG, 3, 32'h0000DEAD, "halted_frozen_r3");
        drain();

        // asynchronous reset while the LDI sits in EXEC
        do_reset();
        dut.mmu.memory[1] = 32'h9E0A1234;
        dut.D.registers[10] = 32'h77;
        go = 1'b1;
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        expect_val(K_PC, 0, 32'h0, "areset_pc");
        expect_val(K_BUSY, 0, 32'h0, "areset_busy");
        drain();
        tick(1);
        expect_val(K_REG, 10, 32'h77, "areset_reg_kept");
        expect_val(K_MEM, 1, 32'h9E0A1234, "areset_mem_kept");
        drain();
        rst_n = 1'b1;
        go    = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
